rom_arbiter: RTL and testbench

//  Shares the single read port of the word-addressed ROM between two requesters:
//  m0 = instruction fetch, m1 = data load. Forwards loader writes to the ROM write port.

---
 rtl/rom_arbiter_if.sv | 35 +++
 rtl/rom_arbiter.sv | 65 ++++++
 tb/tb_rom_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/rom_arbiter_if.sv
// rom_arbiter_if: fetch/load read ports, loader write port and ROM port of the ROM arbiter.
interface rom_arbiter_if #(parameter int DW = 32, parameter int AW = 32);
    logic          m0_req;
    logic [AW-1:0] m0_addr;
    logic          m0_gnt;
    logic          m0_rvalid;
    logic [DW-1:0] m0_rdata;
    logic          m0_err;
    logic          m1_req;
    logic [AW-1:0] m1_addr;
    logic          m1_gnt;
    logic          m1_rvalid;
    logic [DW-1:0] m1_rdata;
    logic          m1_err;
    logic          ld_wen;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic          ld_lock;
    logic          rom_wen;
    logic [AW-1:0] rom_w_addr;
    logic [DW-1:0] rom_w_data;
    logic          rom_ren;
    logic [AW-1:0] rom_r_addr;
    logic [DW-1:0] rom_r_data;
    modport slave (
        input  m0_req, m0_addr, m1_req, m1_addr, ld_wen, ld_addr, ld_wdata, ld_lock, rom_r_data,
        output m0_gnt, m0_rvalid, m0_rdata, m0_err, m1_gnt, m1_rvalid, m1_rdata, m1_err,
               rom_wen, rom_w_addr, rom_w_data, rom_ren, rom_r_addr
    );
    modport master (
        output m0_req, m0_addr, m1_req, m1_addr, ld_wen, ld_addr, ld_wdata, ld_lock, rom_r_data,
        input  m0_gnt, m0_rvalid, m0_rdata, m0_err, m1_gnt, m1_rvalid, m1_rdata, m1_err,
               rom_wen, rom_w_addr, rom_w_data, rom_ren, rom_r_addr
    );
endinterface

// File: rtl/rom_arbiter.sv
// rom_arbiter: round-robin sharing of the ROM read port between fetch (m0) and load (m1),
// with loader write pass-through and same-word write/read bypass.
module rom_arbiter #(
    parameter int DW = 32,
    parameter int AW = 32
) (
    input logic        clk,
    input logic        rstn,
    rom_arbiter_if.slave bus
);
    logic          last_gnt_q, last_gnt_d;
    logic          resp_pend_q, resp_pend_d;
    logic          resp_id_q, resp_id_d;
    logic          err_q, err_d;
    logic          byp_q, byp_d;
    logic [DW-1:0] byp_data_q, byp_data_d;
    logic          g0, g1, hit;
    logic [AW-1:0] gaddr;

    // last_gnt_q = 1 means m1 was granted last, so m0 wins the next contest
    always_comb begin
        g0 = rstn & ~bus.ld_lock & bus.m0_req & (~bus.m1_req | last_gnt_q);
        g1 = rstn & ~bus.ld_lock & bus.m1_req & (~bus.m0_req | ~last_gnt_q);
        gaddr = g1 ? bus.m1_addr : bus.m0_addr;
        hit = bus.ld_wen & (g0 | g1) & (bus.ld_addr[AW-1:2] == gaddr[AW-1:2]);
        last_gnt_d = (g0 | g1) ? g1 : last_gnt_q;
        resp_pend_d = g0 | g1;
        resp_id_d = g1;
        err_d = gaddr[1:0] != 2'b00;
        byp_d = hit;
        byp_data_d = hit ? bus.ld_wdata : byp_data_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_gnt_q  <= 1'b1;
            resp_pend_q <= 1'b0;
            resp_id_q   <= 1'b0;
            err_q       <= 1'b0;
            byp_q       <= 1'b0;
            byp_data_q  <= '0;
        end else begin
            last_gnt_q  <= last_gnt_d;
            resp_pend_q <= resp_pend_d;
            resp_id_q   <= resp_id_d;
            err_q       <= err_d;
            byp_q       <= byp_d;
            byp_data_q  <= byp_data_d;
        end
    end

    assign bus.rom_wen    = bus.ld_wen;
    assign bus.rom_w_addr = bus.ld_addr;
    assign bus.rom_w_data = bus.ld_wdata;
    assign bus.rom_ren    = g0 | g1;
    assign bus.rom_r_addr = gaddr;
    assign bus.m0_gnt     = g0;
    assign bus.m1_gnt     = g1;
    assign bus.m0_rvalid  = resp_pend_q & ~resp_id_q;
    assign bus.m1_rvalid  = resp_pend_q & resp_id_q;
    assign bus.m0_err     = resp_pend_q & ~resp_id_q & err_q;
    assign bus.m1_err     = resp_pend_q & resp_id_q & err_q;
    assign bus.m0_rdata   = byp_q ? byp_data_q : bus.rom_r_data;
    assign bus.m1_rdata   = byp_q ? byp_data_q : bus.rom_r_data;
endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed checks of rom_arbiter against a small behavioural ROM.
module tb_rom_arbiter;
    logic clk = 1'b0;
    logic rstn;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] mem [0:63];

    rom_arbiter_if #(.DW(32), .AW(32)) bus ();
    rom_arbiter #(.DW(32), .AW(32)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    always #5 clk = ~clk;

    // synchronous ROM: 1-cycle read latency, read returns the pre-write contents
    initial for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | i;
    always @(posedge clk) begin
        if (bus.rom_ren) bus.rom_r_data <= mem[bus.rom_r_addr[7:2]];
        if (bus.rom_wen) mem[bus.rom_w_addr[7:2]] <= bus.rom_w_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        rstn = 1'b0;
        bus.m0_req = 1'b1; bus.m0_addr = '0;
        bus.m1_req = 1'b0; bus.m1_addr = '0;
        bus.ld_wen = 1'b0; bus.ld_addr = '0; bus.ld_wdata = '0; bus.ld_lock = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk1("rst_m0_gnt", bus.m0_gnt, 1'b0);
        chk1("rst_rom_ren", bus.rom_ren, 1'b0);
        chk1("rst_m0_rvalid", bus.m0_rvalid, 1'b0);
        chk1("rst_m1_rvalid", bus.m1_rvalid, 1'b0);
        @(negedge clk); rstn = 1'b1; bus.m0_req = 1'b0;
        // single fetch from 0x10
        @(negedge clk); bus.m0_req = 1'b1; bus.m0_addr = 32'h10;
        #1;
        chk1("t1_m0_gnt", bus.m0_gnt, 1'b1);
        chk1("t1_rom_ren", bus.rom_ren, 1'b1);
        chk("t1_r_addr", bus.rom_r_addr, 32'h10);
        // misaligned load from 0x6 overlaps the fetch response
        @(negedge clk); bus.m0_req = 1'b0; bus.m1_req = 1'b1; bus.m1_addr = 32'h6;
        #1;
        chk1("t1_m0_rvalid", bus.m0_rvalid, 1'b1);
        chk("t1_m0_rdata", bus.m0_rdata, 32'hA000_0004);
        chk1("t1_m1_rvalid", bus.m1_rvalid, 1'b0);
        chk1("t1_m0_err", bus.m0_err, 1'b0);
        chk1("t5_m1_gnt", bus.m1_gnt, 1'b1);
        @(negedge clk); bus.m1_req = 1'b0;
        #1;
        chk1("t5_m1_rvalid", bus.m1_rvalid, 1'b1);
        chk1("t5_m1_err", bus.m1_err, 1'b1);
        chk("t5_m1_rdata", bus.m1_rdata, 32'hA000_0001);
        chk1("t5_m0_rvalid", bus.m0_rvalid, 1'b0);
        // both request continuously: alternate m0, m1
        bus.m0_addr = 32'h0; bus.m1_addr = 32'h8;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); bus.m0_req = 1'b1; bus.m1_req = 1'b1;
            #1;
            chk1("t2_m0_gnt", bus.m0_gnt, k % 2 == 0);
            chk1("t2_m1_gnt", bus.m1_gnt, k % 2 == 1);
            if (k > 0) begin
                chk1("t2_m0_rvalid", bus.m0_rvalid, k % 2 == 1);
                chk1("t2_m1_rvalid", bus.m1_rvalid, k % 2 == 0);
                chk("t2_rdata", bus.m0_rdata, (k % 2 == 1) ? 32'hA000_0000 : 32'hA000_0002);
            end
        end
        @(negedge clk); bus.m0_req = 1'b0; bus.m1_req = 1'b0;
        #1;
        chk1("t2_last_m1_rvalid", bus.m1_rvalid, 1'b1);
        chk1("t2_last_m0_rvalid", bus.m0_rvalid, 1'b0);
        chk("t2_last_rdata", bus.m1_rdata, 32'hA000_0002);
        // collision: loader writes 0x20 while m1 reads 0x20
        @(negedge clk);
        bus.m1_req = 1'b1; bus.m1_addr = 32'h20;
        bus.ld_wen = 1'b1; bus.ld_addr = 32'h20; bus.ld_wdata = 32'hDEAD_BEEF;
        #1;
        chk1("t3_m1_gnt", bus.m1_gnt, 1'b1);
        chk1("t3_rom_wen", bus.rom_wen, 1'b1);
        chk("t3_w_addr", bus.rom_w_addr, 32'h20);
        chk("t3_w_data", bus.rom_w_data, 32'hDEAD_BEEF);
        @(negedge clk); bus.ld_wen = 1'b0;
        #1;
        chk1("t3_byp_rvalid", bus.m1_rvalid, 1'b1);
        chk("t3_byp_rdata", bus.m1_rdata, 32'hDEAD_BEEF);
        chk1("t3_m1_gnt2", bus.m1_gnt, 1'b1);
        @(negedge clk); bus.m1_req = 1'b0;
        #1;
        chk1("t3_rd2_rvalid", bus.m1_rvalid, 1'b1);
        chk("t3_rd2_rdata", bus.m1_rdata, 32'hDEAD_BEEF);
        // loader lock blocks all grants
        @(negedge clk);
        bus.ld_lock = 1'b1; bus.m0_req = 1'b1; bus.m1_req = 1'b1;
        bus.m0_addr = 32'h10; bus.m1_addr = 32'h8;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk1("t4_m0_gnt", bus.m0_gnt, 1'b0);
            chk1("t4_m1_gnt", bus.m1_gnt, 1'b0);
            chk1("t4_rom_ren", bus.rom_ren, 1'b0);
            @(negedge clk);
        end
        bus.ld_lock = 1'b0;
        #1;
        chk1("t4_rel_m0_gnt", bus.m0_gnt, 1'b1);
        chk1("t4_rel_m1_gnt", bus.m1_gnt, 1'b0);
        @(negedge clk); bus.ld_lock = 1'b1;
        #1;
        chk1("t4_pend_rvalid", bus.m0_rvalid, 1'b1);
        chk("t4_pend_rdata", bus.m0_rdata, 32'hA000_0004);
        chk1("t4_pend_gnt", bus.m0_gnt, 1'b0);
        // reset with a read in flight
        @(negedge clk); bus.ld_lock = 1'b0; bus.m1_req = 1'b0;
        #1;
        chk1("t6_m0_gnt", bus.m0_gnt, 1'b1);
        @(posedge clk); #1; rstn = 1'b0; bus.m0_req = 1'b0;
        #1;
        chk1("t6_rst_rvalid", bus.m0_rvalid, 1'b0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            chk1("t6_post_rvalid", bus.m0_rvalid, 1'b0);
        end
        bus.m0_req = 1'b1; bus.m1_req = 1'b1;
        #1;
        chk1("t6_first_m0_gnt", bus.m0_gnt, 1'b1);
        chk1("t6_first_m1_gnt", bus.m1_gnt, 1'b0);
        @(negedge clk); bus.m0_req = 1'b0; bus.m1_req = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
